divider_config_ctrl: RTL and testbench

DIVIDER_CONFIG_CTRL -- requirements
Module: divider_config_ctrl

---
 rtl/divctrl_pkg.sv | 15 +
 rtl/divctrl_serializer.sv | 72 +++++++
 rtl/divider_config_ctrl.sv | 124 ++++++++++++
 tb/tb_divider_config_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/divctrl_pkg.sv
// Shared types and constants for the divider configuration controller.
package divctrl_pkg;

  localparam int DIV_TARGET_W = 32;
  localparam int MIN_TARGET   = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HALT   = 3'd1,
    CLEAR  = 3'd2,
    SHIFT  = 3'd3,
    RESYNC = 3'd4
  } divctrl_state_e;

endpackage

// File: rtl/divctrl_serializer.sv
// Shifts a target out MSB first: each bit is set up for SCLK_HALF cycles with the clock low,
// then held for SCLK_HALF cycles with the clock high. One-cycle start in, one-cycle last-bit out.
module divctrl_serializer
  import divctrl_pkg::*;
#(
  parameter int SCLK_HALF = 2,
  parameter int TARGET_W  = DIV_TARGET_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic [TARGET_W-1:0] i_data,
  output logic                o_sr_data,
  output logic                o_sr_clk,
  output logic                o_last
);

  localparam int CNT_W = $clog2(TARGET_W) + 1;
  localparam int PH_W  = 8;
  localparam logic [PH_W-1:0]  PH_LAST = PH_W'(SCLK_HALF - 1);
  localparam logic [CNT_W-1:0] BITS    = CNT_W'(TARGET_W);

  logic                r_active;
  logic [TARGET_W-1:0] r_shreg;
  logic [PH_W-1:0]     r_phase;
  logic [CNT_W-1:0]    r_bitcnt;
  logic                r_sclk;

  logic                w_phase_end;
  logic                w_bit_end;
  logic [CNT_W-1:0]    w_bitcnt_nxt;

  assign w_phase_end  = r_active && (r_phase == PH_LAST);
  assign w_bit_end    = w_phase_end && r_sclk;
  assign w_bitcnt_nxt = r_bitcnt + CNT_W'(1);
  assign o_last       = w_bit_end && (w_bitcnt_nxt == BITS);
  assign o_sr_data    = r_shreg[TARGET_W-1];
  assign o_sr_clk     = r_sclk;

  // The bit counter stops at TARGET_W because the serializer goes inactive there.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_active <= 1'b0;
      r_shreg  <= '0;
      r_phase  <= '0;
      r_bitcnt <= '0;
      r_sclk   <= 1'b0;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_shreg  <= i_data;
      r_phase  <= '0;
      r_bitcnt <= '0;
      r_sclk   <= 1'b0;
    end else if (w_phase_end) begin
      r_phase <= '0;
      if (!r_sclk) begin
        r_sclk <= 1'b1;
      end else begin
        r_sclk   <= 1'b0;
        r_bitcnt <= w_bitcnt_nxt;
        r_shreg  <= {r_shreg[TARGET_W-2:0], 1'b0};
        if (w_bitcnt_nxt == BITS) begin
          r_active <= 1'b0;
          r_shreg  <= '0;
        end
      end
    end else if (r_active) begin
      r_phase <= r_phase + PH_W'(1);
    end
  end

endmodule

// File: rtl/divider_config_ctrl.sv
// Loads a divide target into the divider shift register (halt, clear, shift, resync), then re-enables
// the divider from run_request. Optional DIVCTRL_RANGE_CHECK_EN rejects targets below MIN_TARGET.
module divider_config_ctrl
  import divctrl_pkg::*;
#(
  parameter int SCLK_HALF = 2,
  parameter int TARGET_W  = DIV_TARGET_W
) (
  input  logic                sys_clock,
  input  logic                sys_reset,
  input  logic [TARGET_W-1:0] load_target,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic                run_request,
  output logic                load_done,
  output logic                load_error,
  output logic                sr_data,
  output logic                sr_data_clock,
  output logic                sr_div_data_enable,
  output logic                sr_div_data_reset,
  output logic                div_enable,
  output logic                div_reset
);

  divctrl_state_e      r_state;
  divctrl_state_e      w_state_nxt;
  logic [TARGET_W-1:0] r_shadow;
  logic                r_loaded;
  logic                r_done;
  logic                r_div_enable;
  logic                w_accept;
  logic                w_reject;
  logic                w_start;
  logic                w_last;

  assign load_ready = (r_state == IDLE) && !sys_reset;
  assign w_accept   = load_valid && load_ready;

`ifdef DIVCTRL_RANGE_CHECK_EN
  logic r_error;
  assign w_reject   = w_accept && (load_target < TARGET_W'(MIN_TARGET));
  assign load_error = r_error;

  always_ff @(posedge sys_clock) begin
    if (sys_reset) begin
      r_error <= 1'b0;
    end else if (w_accept) begin
      r_error <= w_reject;
    end
  end
`else
  assign w_reject   = 1'b0;
  assign load_error = 1'b0;
`endif

  always_ff @(posedge sys_clock) begin
    if (sys_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    case (r_state)
      IDLE:   if (w_accept && !w_reject) w_state_nxt = HALT;
      HALT:   w_state_nxt = CLEAR;
      CLEAR: begin
        w_start     = 1'b1;
        w_state_nxt = SHIFT;
      end
      SHIFT:  if (w_last) w_state_nxt = RESYNC;
      RESYNC: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clock) begin
    if (w_accept) begin
      r_shadow <= load_target;
    end
  end

  // A real load takes priority over run_request, so the divider stops the cycle HALT is entered.
  always_ff @(posedge sys_clock) begin
    if (sys_reset) begin
      r_loaded     <= 1'b0;
      r_done       <= 1'b0;
      r_div_enable <= 1'b0;
    end else begin
      r_done <= w_reject || (r_state == RESYNC);
      if (r_state == RESYNC) begin
        r_loaded <= 1'b1;
      end
      if ((r_state == IDLE) && !(w_accept && !w_reject)) begin
        r_div_enable <= run_request && r_loaded;
      end else begin
        r_div_enable <= 1'b0;
      end
    end
  end

  divctrl_serializer #(
    .SCLK_HALF (SCLK_HALF),
    .TARGET_W  (TARGET_W)
  ) u_serializer (
    .clk       (sys_clock),
    .rst       (sys_reset),
    .i_start   (w_start),
    .i_data    (r_shadow),
    .o_sr_data (sr_data),
    .o_sr_clk  (sr_data_clock),
    .o_last    (w_last)
  );

  assign load_done          = r_done;
  assign sr_div_data_enable = (r_state == SHIFT);
  assign sr_div_data_reset  = (r_state == CLEAR);
  assign div_enable         = r_div_enable;
  assign div_reset          = sys_reset || (r_state == RESYNC);

endmodule

// File: tb/tb_divider_config_ctrl.sv
// Bench for divider_config_ctrl: timeline-based reference model compared every cycle, plus literal checks.
module tb_divider_config_ctrl;

  localparam int W = 32;
  localparam int H = 2;
  localparam int S = W * 2 * H;

`ifdef DIVCTRL_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         lv  = 1'b0;
  logic         run = 1'b0;
  logic [W-1:0] lt  = '0;
  logic ready, done, err, sd, sclk, sen, srst, den, drst;

  divider_config_ctrl #(.SCLK_HALF(H), .TARGET_W(W)) dut (
    .sys_clock          (clk),
    .sys_reset          (rst),
    .load_target        (lt),
    .load_valid         (lv),
    .load_ready         (ready),
    .run_request        (run),
    .load_done          (done),
    .load_error         (err),
    .sr_data            (sd),
    .sr_data_clock      (sclk),
    .sr_div_data_enable (sen),
    .sr_div_data_reset  (srst),
    .div_enable         (den),
    .div_reset          (drst)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Model: a load is a timeline indexed by cycles since acceptance (1=HALT, 2=CLEAR, 3..2+S=SHIFT, 3+S=RESYNC).
  bit           m_ok = 1'b0;
  bit           m_busy, m_loaded, m_err, m_den, m_done;
  int           m_k;
  logic [W-1:0] m_tgt;

  int           acc_cyc, done_cyc, rises, acc_count, drst_cnt;
  logic [W-1:0] cap;
  logic         prev_sclk = 1'b0;

  function automatic logic [8:0] model_out();
    bit   sh;
    int   j;
    logic e_sd, e_sclk;
    sh     = m_busy && (m_k >= 3) && (m_k <= 2 + S);
    e_sd   = 1'b0;
    e_sclk = 1'b0;
    if (sh) begin
      j      = m_k - 3;
      e_sclk = (j % (2 * H)) >= H;
      e_sd   = m_tgt[W - 1 - j / (2 * H)];
    end
    return {!m_busy && !rst, m_done, m_err, e_sd, e_sclk, sh,
            m_busy && (m_k == 2), m_den, rst || (m_busy && (m_k == 3 + S))};
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_ok = 1'b1; m_busy = 1'b0; m_loaded = 1'b0; m_err = 1'b0; m_done = 1'b0; m_den = 1'b0;
    end else if (m_ok) begin
      m_done = 1'b0;
      if (m_busy) begin
        m_den = 1'b0;
        m_k++;
        if (m_k == 4 + S) begin
          m_busy = 1'b0; m_loaded = 1'b1; m_done = 1'b1;
        end
      end else if (lv) begin
        if (RC && (lt < 2)) begin
          m_done = 1'b1; m_err = 1'b1; m_den = run && m_loaded;
        end else begin
          m_busy = 1'b1; m_k = 1; m_tgt = lt; m_err = 1'b0; m_den = 1'b0;
        end
      end else begin
        m_den = run && m_loaded;
      end
    end
  endtask

  task automatic step();
    logic [8:0] e, a;
    if (m_ok && lv && !m_busy && !rst) begin
      acc_cyc = cyc;
      acc_count++;
    end
    @(posedge clk);
    model_edge();
    cyc++;
    @(negedge clk);
    if (m_ok) begin
      e = model_out();
      a = {ready, done, err, sd, sclk, sen, srst, den, drst};
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL cycle_outputs cyc=%0d got=%b want=%b (ready,done,err,sd,sclk,sen,srst,den,drst)",
                 cyc, a, e);
      end
    end
    if (sclk && !prev_sclk) begin
      rises++;
      cap = {cap[W-2:0], sd};
    end
    prev_sclk = sclk;
    if (done) done_cyc = cyc;
    if (drst && !rst) drst_cnt++;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s timeout at cyc=%0d", name, cyc);
  endtask

  task automatic clear_obs();
    rises = 0; cap = '0; drst_cnt = 0; done_cyc = -1;
  endtask

  // Holds load_valid until the model says the controller accepts, then drops it after that edge.
  task automatic do_load(input logic [W-1:0] t);
    int n = 0;
    lt = t;
    lv = 1'b1;
    while ((m_busy || rst) && n < 400) begin
      step();
      n++;
    end
    if (n >= 400) timeout("load_accept");
    step();
    lv = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (m_busy && n < 400) begin
      step();
      n++;
    end
    if (n >= 400) timeout("wait_idle");
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int n;
    clear_obs();
    acc_count = 0;

    // Reset state.
    repeat (3) step();
    check("rst_ready", ready, 0);
    check("rst_div_reset", drst, 1);
    check("rst_div_enable", den, 0);
    check("rst_sr_clk", sclk, 0);
    rst = 1'b0;
    step();
    check("ready_after_release", ready, 1);
    check("div_reset_after_release", drst, 0);

    // run_request before any load keeps the divider stopped.
    run = 1'b1;
    repeat (5) step();
    check("den_before_load", den, 0);

    // Load 0xA: 32 clock edges, value MSB first, done 132 cycles after acceptance.
    clear_obs();
    do_load(32'h0000_000A);
    wait_idle();
    check("a_rises", rises, 32);
    check("a_bits", cap, 32'h0000_000A);
    check("a_done_latency", done_cyc - acc_cyc, 132);
    check("a_den_first_idle", den, 0);
    step();
    check("a_den_after_idle", den, 1);

    // Load 0x4 then all-ones while running.
    do_load(32'h4);
    wait_idle();
    step();
    check("b_den_running", den, 1);
    clear_obs();
    do_load(32'hFFFF_FFFF);
    check("c_den_halt", den, 0);
    wait_idle();
    check("c_bits", cap, 32'hFFFF_FFFF);
    check("c_rises", rises, 32);
    check("c_resync_pulses", drst_cnt, 1);

    // Small targets.
    clear_obs();
    do_load(32'h1);
    if (RC) begin
      check("r_done_pulse", done, 1);
      check("r_error", err, 1);
      repeat (4) step();
      check("r_no_shift", rises, 0);
      do_load(32'h2);
      check("r_error_cleared", err, 0);
      wait_idle();
    end else begin
      wait_idle();
      check("n_error_tied", err, 0);
      check("n_bits", cap, 32'h1);
    end

    // Reset at the first cycle of bit 17 of SHIFT.
    do_load(32'h1234_5678);
    n = 0;
    while (m_k != 3 + 17 * 2 * H && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) timeout("reach_bit17");
    rst = 1'b1;
    step();
    check("m_sen", sen, 0);
    check("m_sclk", sclk, 0);
    check("m_sd", sd, 0);
    check("m_den", den, 0);
    check("m_drst", drst, 1);
    check("m_ready", ready, 0);
    rst = 1'b0;
    step();
    check("m_ready_release", ready, 1);
    repeat (2) step();
    check("m_loaded_cleared", den, 0);
    clear_obs();
    do_load(32'h5);
    wait_idle();
    check("m_reload_bits", cap, 32'h5);
    check("m_reload_done", done, 1);

    // load_valid held through SHIFT is accepted once, on the first IDLE cycle.
    do_load(32'h0F0F_0F0F);
    repeat (20) step();
    a0 = acc_count;
    do_load(32'h3C);
    check("h_single_accept", acc_count - a0, 1);
    check("h_accept_at_idle", acc_cyc, done_cyc);
    wait_idle();

    // Randomized traffic with occasional mid-load reset.
    for (int it = 0; it < 15; it++) begin
      int gap;
      logic [W-1:0] t;
      gap = $urandom_range(0, 5);
      for (int g = 0; g < gap; g++) begin
        run = 1'($urandom_range(0, 1));
        step();
      end
      t = $urandom();
      if ($urandom_range(0, 3) == 0) t = W'($urandom_range(0, 3));
      do_load(t);
      if ($urandom_range(0, 7) == 0) begin
        repeat ($urandom_range(0, 140)) step();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        step();
      end else begin
        while (m_busy) begin
          run = 1'($urandom_range(0, 1));
          step();
          if (m_k > 4 + S) break;
        end
      end
    end
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
